// File: rtl/embedded_io_ctrl_pkg.sv
// Shared types and constants for the embedded I/O controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package embedded_io_ctrl_pkg;

  // Isolation sequencer states
  typedef enum logic [1:0] {
    ISOLATED = 2'd0,
    WAIT     = 2'd1,
    ACTIVE   = 2'd2
  } state_e;

  // Largest bank the controller is meant to be built for
  localparam int MAX_NUM_IO = 32;

  // Width of the isolation delay counter for a given delay
  function automatic int cnt_width(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/embedded_io_ctrl_if.sv
// Host and fabric signals of one embedded I/O bank.
// Latency: n/a (wires only).
// Backpressure: none; all strobes are single-cycle and always accepted.
interface embedded_io_ctrl_if #(
  parameter int NUM_IO = 8
);
  logic              CFG_DONE;
  logic              ISOL_REQ;
  logic              WR_EN;
  logic [NUM_IO-1:0] WR_DATA;
  logic [NUM_IO-1:0] IRQ_CLR;
  logic [NUM_IO-1:0] SOC_IN;
  logic [NUM_IO-1:0] SOC_OUT;
  logic [NUM_IO-1:0] SOC_DIR;
  logic              IO_ISOL_N;
  logic [NUM_IO-1:0] RD_DATA;
  logic [NUM_IO-1:0] IRQ_STATUS;
  logic              EDGE_IRQ;

  // Host/fabric side: drives stimulus, observes controller outputs
  modport master (
    output CFG_DONE, ISOL_REQ, WR_EN, WR_DATA, IRQ_CLR, SOC_OUT, SOC_DIR,
    input  SOC_IN, IO_ISOL_N, RD_DATA, IRQ_STATUS, EDGE_IRQ
  );

  // Controller side
  modport slave (
    input  CFG_DONE, ISOL_REQ, WR_EN, WR_DATA, IRQ_CLR, SOC_OUT, SOC_DIR,
    output SOC_IN, IO_ISOL_N, RD_DATA, IRQ_STATUS, EDGE_IRQ
  );
endinterface

// File: rtl/embedded_io_ctrl_sync.sv
// Multi-flop synchronizer for asynchronous fabric-side signals.
// Latency: STAGES cycles from din to dout.
// Backpressure: none; samples every cycle.
module io_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  // Shift the sampled value one stage per cycle
  always_comb begin
    sync_d    = '0;
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain flops, cleared asynchronously
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];
endmodule

// File: rtl/embedded_io_ctrl.sv
// SoC-side embedded I/O controller: output register, synchronized readback, edge IRQ, isolation sequencing.
// Latency: SOC_IN 1 cycle; SOC_OUT->RD_DATA SYNC_STAGES+1; RD_DATA rise->IRQ_STATUS 1; CFG_DONE->IO_ISOL_N SYNC_STAGES+1+ISOL_DELAY.
// Backpressure: none; every strobe is accepted. Optional macro EMBEDDED_IO_CTRL_FALL_EDGE_EN adds falling-edge status.
module embedded_io_ctrl
  import embedded_io_ctrl_pkg::*;
#(
  parameter int NUM_IO      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ISOL_DELAY  = 16
) (
  input logic                 CK,
  input logic                 RSTN,
  embedded_io_ctrl_if.slave   io
);
  localparam int                CNT_W    = cnt_width(ISOL_DELAY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ISOL_DELAY - 1);

  logic [NUM_IO-1:0] out_s, dir_s;
  logic              cfg_s;

  io_sync #(.WIDTH(NUM_IO), .STAGES(SYNC_STAGES)) u_sync_out (
    .CK(CK), .RSTN(RSTN), .din(io.SOC_OUT), .dout(out_s));
  io_sync #(.WIDTH(NUM_IO), .STAGES(SYNC_STAGES)) u_sync_dir (
    .CK(CK), .RSTN(RSTN), .din(io.SOC_DIR), .dout(dir_s));
  io_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_cfg (
    .CK(CK), .RSTN(RSTN), .din(io.CFG_DONE), .dout(cfg_s));

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              isol_n_q, isol_n_d;
  logic [NUM_IO-1:0] soc_in_q, soc_in_d;
  logic [NUM_IO-1:0] rd_q, rd_d;
  logic [NUM_IO-1:0] prev_q, prev_d;
  logic [NUM_IO-1:0] status_q, status_d;
  logic              edge_irq_q, edge_irq_d;
  logic [NUM_IO-1:0] set_v;

  // Isolation sequencer: release only after cfg_s has stayed high for ISOL_DELAY cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    isol_n_d = isol_n_q;
    case (state_q)
      ISOLATED: begin
        isol_n_d = 1'b0;
        cnt_d    = '0;
        if (cfg_s && !io.ISOL_REQ) state_d = WAIT;
      end
      WAIT: begin
        if (!cfg_s || io.ISOL_REQ) begin
          state_d  = ISOLATED;
          cnt_d    = '0;
          isol_n_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ACTIVE;
          cnt_d    = '0;
          isol_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!cfg_s || io.ISOL_REQ) begin
          state_d  = ISOLATED;
          cnt_d    = '0;
          isol_n_d = 1'b0;
        end
      end
      default: begin
        state_d  = ISOLATED;
        cnt_d    = '0;
        isol_n_d = 1'b0;
      end
    endcase
  end

`ifdef EMBEDDED_IO_CTRL_FALL_EDGE_EN
  // Remembers which bits were unmasked when rd_q was computed, so falls caused by masking are ignored
  logic [NUM_IO-1:0] mask_q, mask_d;
  assign mask_d = (state_q == ACTIVE) ? ~dir_s : '0;
  assign set_v  = (rd_q & ~prev_q) | (prev_q & ~rd_q & mask_q);

  // Mask history register
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) mask_q <= '0;
    else       mask_q <= mask_d;
  end
`else
  assign set_v = rd_q & ~prev_q;
`endif

  // Data path: output register, masked readback, sticky status with set beating clear
  always_comb begin
    soc_in_d   = io.WR_EN ? io.WR_DATA : soc_in_q;
    rd_d       = (state_q == ACTIVE) ? (out_s & ~dir_s) : '0;
    prev_d     = rd_q;
    status_d   = (status_q & ~io.IRQ_CLR) | set_v;
    edge_irq_d = |status_d;
  end

  // All controller state, cleared asynchronously
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ISOLATED;
      cnt_q      <= '0;
      isol_n_q   <= 1'b0;
      soc_in_q   <= '0;
      rd_q       <= '0;
      prev_q     <= '0;
      status_q   <= '0;
      edge_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isol_n_q   <= isol_n_d;
      soc_in_q   <= soc_in_d;
      rd_q       <= rd_d;
      prev_q     <= prev_d;
      status_q   <= status_d;
      edge_irq_q <= edge_irq_d;
    end
  end

  assign io.SOC_IN     = soc_in_q;
  assign io.IO_ISOL_N  = isol_n_q;
  assign io.RD_DATA    = rd_q;
  assign io.IRQ_STATUS = status_q;
  assign io.EDGE_IRQ   = edge_irq_q;
endmodule

// File: tb/tb_embedded_io_ctrl.sv
// Directed bench for embedded_io_ctrl with an expected-value queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_embedded_io_ctrl;
  localparam int N = 8;

  logic CK = 1'b0;
  logic RSTN;
  always #5 CK = ~CK;

  embedded_io_ctrl_if #(.NUM_IO(N)) io ();

  embedded_io_ctrl #(.NUM_IO(N), .SYNC_STAGES(2), .ISOL_DELAY(16)) dut (
    .CK(CK), .RSTN(RSTN), .io(io.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CK);
  endtask

  // Counts edges until IO_ISOL_N rises; other outputs must stay zero meanwhile
  task automatic wait_release(input string tag, input int exp_n);
    int          n;
    logic [31:0] quiet;
    n     = 0;
    quiet = '0;
    expect_v({tag, "_lat"}, 32'(exp_n));
    expect_v({tag, "_quiet"}, 32'h0);
    while (n < 60 && io.IO_ISOL_N !== 1'b1) begin
      @(negedge CK);
      n++;
      quiet = quiet | 32'(io.RD_DATA) | 32'(io.IRQ_STATUS) | 32'(io.EDGE_IRQ);
    end
    observe(32'(n));
    observe(quiet);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    RSTN = 1'b0;
    io.CFG_DONE = 1'b0; io.ISOL_REQ = 1'b0; io.WR_EN = 1'b0;
    io.WR_DATA = '0; io.IRQ_CLR = '0; io.SOC_OUT = '0; io.SOC_DIR = '0;
    cyc(3);

    // Reset state
    expect_v("rst_soc_in", 0);   observe(32'(io.SOC_IN));
    expect_v("rst_isol_n", 0);   observe(32'(io.IO_ISOL_N));
    expect_v("rst_rd_data", 0);  observe(32'(io.RD_DATA));
    expect_v("rst_status", 0);   observe(32'(io.IRQ_STATUS));
    expect_v("rst_edge_irq", 0); observe(32'(io.EDGE_IRQ));

    // Release: 2 sync edges, 1 edge into WAIT, 16 edges of delay
    RSTN = 1'b1;
    cyc(2);
    io.CFG_DONE = 1'b1;
    wait_release("release", 19);

    // Write path, held across isolation changes
    io.WR_EN = 1'b1; io.WR_DATA = 8'hA5;
    expect_v("soc_in_wr", 32'hA5);
    cyc(1);
    io.WR_EN = 1'b0; io.WR_DATA = 8'h3C;
    observe(32'(io.SOC_IN));
    io.ISOL_REQ = 1'b1;
    expect_v("isol_req_active", 0);
    cyc(1);
    observe(32'(io.IO_ISOL_N));
    cyc(2);
    expect_v("soc_in_hold_isol", 32'hA5); observe(32'(io.SOC_IN));
    io.ISOL_REQ = 1'b0;
    wait_release("rerelease", 17);
    expect_v("soc_in_hold_active", 32'hA5); observe(32'(io.SOC_IN));

    // Edge capture on bit 3
    io.SOC_OUT[3] = 1'b1;
    expect_v("rd3_lat", 3);
    expect_v("rd_b3", 32'h08);
    n = 0;
    while (n < 20 && io.RD_DATA[3] !== 1'b1) begin
      @(negedge CK);
      n++;
    end
    observe(32'(n));
    observe(32'(io.RD_DATA));
    cyc(1);
    expect_v("status_b3", 32'h08); observe(32'(io.IRQ_STATUS));
    expect_v("edge_irq_b3", 1);    observe(32'(io.EDGE_IRQ));
    io.IRQ_CLR = 8'h08;
    cyc(1);
    io.IRQ_CLR = '0;
    expect_v("status_clr_b3", 0);  observe(32'(io.IRQ_STATUS));
    expect_v("edge_irq_clr", 0);   observe(32'(io.EDGE_IRQ));

    // Set and clear in the same cycle: set wins
    io.SOC_OUT[0] = 1'b1;
    cyc(3);
    io.IRQ_CLR = 8'h01;
    cyc(1);
    io.IRQ_CLR = '0;
    expect_v("collision_status", 32'h01); observe(32'(io.IRQ_STATUS));
    io.IRQ_CLR = 8'h01;
    cyc(1);
    io.IRQ_CLR = '0;
    expect_v("collision_clr", 0); observe(32'(io.IRQ_STATUS));

    // Direction masking on bit 5
    io.SOC_DIR[5] = 1'b1; io.SOC_OUT[5] = 1'b1;
    cyc(6);
    expect_v("dir_masked_rd", 32'h09);   observe(32'(io.RD_DATA));
    expect_v("dir_masked_status", 0);    observe(32'(io.IRQ_STATUS));
    io.SOC_DIR[5] = 1'b0;
    cyc(3);
    expect_v("dir_unmask_rd", 32'h29);   observe(32'(io.RD_DATA));
    cyc(1);
    expect_v("dir_unmask_status", 32'h20); observe(32'(io.IRQ_STATUS));
    expect_v("dir_unmask_irq", 1);         observe(32'(io.EDGE_IRQ));
    io.IRQ_CLR = 8'hFF;
    cyc(1);
    io.IRQ_CLR = '0;
    expect_v("clr_all", 0); observe(32'(io.IRQ_STATUS));

    // Abort in ACTIVE: isolate next edge, readback cleared, no status
    io.ISOL_REQ = 1'b1;
    cyc(1);
    expect_v("abort_active_isol", 0); observe(32'(io.IO_ISOL_N));
    cyc(1);
    expect_v("abort_active_rd", 0);   observe(32'(io.RD_DATA));
    cyc(3);
    expect_v("abort_active_status", 0); observe(32'(io.IRQ_STATUS));
    expect_v("abort_active_irq", 0);    observe(32'(io.EDGE_IRQ));

    // Abort mid-WAIT with counter at 7
    io.ISOL_REQ = 1'b0;
    cyc(8);
    expect_v("mid_wait_isol", 0); observe(32'(io.IO_ISOL_N));
    io.ISOL_REQ = 1'b1;
    cyc(20);
    expect_v("held_isol", 0); observe(32'(io.IO_ISOL_N));
    io.ISOL_REQ = 1'b0;
    wait_release("after_abort", 17);

    // Entering ACTIVE with out_s high counts as rises
    cyc(1);
    expect_v("enter_active_rd", 32'h29);     observe(32'(io.RD_DATA));
    cyc(1);
    expect_v("enter_active_status", 32'h29); observe(32'(io.IRQ_STATUS));
    expect_v("enter_active_irq", 1);         observe(32'(io.EDGE_IRQ));

    // Asynchronous reset while ACTIVE
    #2;
    RSTN = 1'b0;
    #1;
    expect_v("arst_isol", 0);   observe(32'(io.IO_ISOL_N));
    expect_v("arst_soc_in", 0); observe(32'(io.SOC_IN));
    expect_v("arst_rd", 0);     observe(32'(io.RD_DATA));
    expect_v("arst_status", 0); observe(32'(io.IRQ_STATUS));
    expect_v("arst_irq", 0);    observe(32'(io.EDGE_IRQ));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
